// File: rtl/pc_predictor_if.sv
// Fetch/resolve bundle between the fetcher, the branch-resolution path and
// the next-PC generator.
interface pc_predictor_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              ena;
  logic              in_fetcher_ena;
  logic [DATA_W-1:0] in_last_pc;
  logic [DATA_W-1:0] in_last_inst;
  logic [DATA_W-1:0] out_next_pc;
  logic              out_next_taken;
  logic [DATA_W-1:0] out_rollback_pc;
  logic              out_rollback;
  logic              in_misbranch;
  logic              in_update_valid;
  logic              in_forwarding_branch_taken;
  logic [DATA_W-1:0] in_forwarding_branch_pc;
  logic [DATA_W-1:0] in_forwarding_correct_address;
  logic [CNT_W-1:0]  out_mispredict_cnt;

  modport master (
    output ena, in_fetcher_ena, in_last_pc, in_last_inst,
    output in_misbranch, in_update_valid, in_forwarding_branch_taken,
    output in_forwarding_branch_pc, in_forwarding_correct_address,
    input  out_next_pc, out_next_taken, out_rollback_pc, out_rollback,
    input  out_mispredict_cnt
  );

  modport slave (
    input  ena, in_fetcher_ena, in_last_pc, in_last_inst,
    input  in_misbranch, in_update_valid, in_forwarding_branch_taken,
    input  in_forwarding_branch_pc, in_forwarding_correct_address,
    output out_next_pc, out_next_taken, out_rollback_pc, out_rollback,
    output out_mispredict_cnt
  );
endinterface

// File: rtl/pc_predictor.sv
// Next-PC generator with a bimodal table of saturating counters, trained by
// resolved branches and overridden by misbranch redirects.
module pc_predictor #(
  parameter int              DATA_W    = 32,
  parameter int              IDX_BITS  = 6,
  parameter int              CNT_BITS  = 2,
  parameter int              PRED_MODE = 1,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int              CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  pc_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [CNT_BITS-1:0] cnt_table [ENTRIES];
  logic [DATA_W-1:0]   next_pc_reg, next_pc_next;
  logic [CNT_W-1:0]    mis_cnt_reg, mis_cnt_next;

  logic [6:0]          opcode;
  logic [DATA_W-1:0]   b_imm, j_imm, pc_plus4;
  logic [IDX_BITS-1:0] lookup_idx, update_idx;
  logic                pred_taken;

  assign opcode     = bus.in_last_inst[6:0];
  assign b_imm      = {{(DATA_W-13){bus.in_last_inst[31]}}, bus.in_last_inst[31],
                       bus.in_last_inst[7], bus.in_last_inst[30:25],
                       bus.in_last_inst[11:8], 1'b0};
  assign j_imm      = {{(DATA_W-21){bus.in_last_inst[31]}}, bus.in_last_inst[31],
                       bus.in_last_inst[19:12], bus.in_last_inst[20],
                       bus.in_last_inst[30:25], bus.in_last_inst[24:21], 1'b0};
  assign pc_plus4   = bus.in_last_pc + DATA_W'(4);
  assign lookup_idx = bus.in_last_pc[IDX_BITS+1:2];
  assign update_idx = bus.in_forwarding_branch_pc[IDX_BITS+1:2];
  assign pred_taken = (PRED_MODE == 1) && cnt_table[lookup_idx][CNT_BITS-1];

  // Each entry is its own register so the whole table clears in one reset cycle.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [CNT_BITS-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= CNT_INIT;
        end else if (bus.ena && bus.in_update_valid && update_idx == IDX_BITS'(gi)) begin
          if (bus.in_forwarding_branch_taken) begin
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
          end else begin
            if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
          end
        end
      end
      assign cnt_table[gi] = cnt_reg;
    end
  endgenerate

  always_comb begin
    next_pc_next = next_pc_reg;
    if (bus.ena) begin
      if (bus.in_misbranch) begin
        next_pc_next = bus.in_forwarding_correct_address;
      end else if (bus.in_fetcher_ena) begin
        case (opcode)
          OP_JAL:    next_pc_next = bus.in_last_pc + j_imm;
          OP_BRANCH: next_pc_next = pred_taken ? bus.in_last_pc + b_imm : pc_plus4;
          default:   next_pc_next = pc_plus4;
        endcase
      end
    end
  end

  always_comb begin
    mis_cnt_next = mis_cnt_reg;
    if (bus.ena && bus.in_misbranch && mis_cnt_reg != {CNT_W{1'b1}})
      mis_cnt_next = mis_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc_reg <= RESET_PC;
      mis_cnt_reg <= '0;
    end else begin
      next_pc_reg <= next_pc_next;
      mis_cnt_reg <= mis_cnt_next;
    end
  end

  assign bus.out_next_pc        = next_pc_reg;
  assign bus.out_next_taken     = (opcode == OP_BRANCH) && pred_taken;
  assign bus.out_rollback_pc    = bus.in_forwarding_correct_address;
  assign bus.out_rollback       = bus.in_misbranch;
  assign bus.out_mispredict_cnt = mis_cnt_reg;

  // Only the index bits of the resolved-branch PC select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.in_forwarding_branch_pc[DATA_W-1:IDX_BITS+2],
                            bus.in_forwarding_branch_pc[1:0]};
endmodule

// File: tb/tb_pc_predictor.sv
// Drives a bimodal and a static-not-taken predictor with identical stimulus
// and compares both against a behavioural model.
module tb_pc_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_predictor_if #(.DATA_W(32), .CNT_W(16)) bus1 ();
  pc_predictor_if #(.DATA_W(32), .CNT_W(16)) bus0 ();

  pc_predictor #(.DATA_W(32), .IDX_BITS(6), .CNT_BITS(2), .PRED_MODE(1),
                 .RESET_PC(32'h100), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pc_predictor #(.DATA_W(32), .IDX_BITS(6), .CNT_BITS(2), .PRED_MODE(0),
                 .RESET_PC(32'h100), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus0.ena                           = bus1.ena;
  assign bus0.in_fetcher_ena                = bus1.in_fetcher_ena;
  assign bus0.in_last_pc                    = bus1.in_last_pc;
  assign bus0.in_last_inst                  = bus1.in_last_inst;
  assign bus0.in_misbranch                  = bus1.in_misbranch;
  assign bus0.in_update_valid               = bus1.in_update_valid;
  assign bus0.in_forwarding_branch_taken    = bus1.in_forwarding_branch_taken;
  assign bus0.in_forwarding_branch_pc       = bus1.in_forwarding_branch_pc;
  assign bus0.in_forwarding_correct_address = bus1.in_forwarding_correct_address;

  logic [31:0] npc [2];
  logic        ntk [2];
  logic [15:0] mcnt [2];
  logic        rb [2];
  logic [31:0] rbpc [2];
  assign npc[0] = bus0.out_next_pc;     assign npc[1] = bus1.out_next_pc;
  assign ntk[0] = bus0.out_next_taken;  assign ntk[1] = bus1.out_next_taken;
  assign mcnt[0] = bus0.out_mispredict_cnt; assign mcnt[1] = bus1.out_mispredict_cnt;
  assign rb[0] = bus0.out_rollback;     assign rb[1] = bus1.out_rollback;
  assign rbpc[0] = bus0.out_rollback_pc; assign rbpc[1] = bus1.out_rollback_pc;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: counters as plain integers 0..3, PCs per mode.
  int          tbl_m [64];
  logic [31:0] pc_m [2];
  int          cnt_m;

  localparam logic [31:0] INST_ALU  = 32'h00000013;
  localparam logic [31:0] INST_JAL8 = 32'hFF9FF06F;
  localparam logic [31:0] INST_BEQ16 = 32'h00000863;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int b_offset(input logic [31:0] inst);
    return (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
           + int'(inst[11:8]) * 2;
  endfunction

  function automatic int j_offset(input logic [31:0] inst);
    return (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
           + int'(inst[30:21]) * 2;
  endfunction

  function automatic logic model_taken(input int mode, input logic [31:0] pc, input logic [31:0] inst);
    return (mode == 1) && (inst[6:0] == 7'b1100011) && (tbl_m[idx_of(pc)] >= 2);
  endfunction

  task automatic model_step();
    logic [31:0] pc, inst;
    pc = bus1.in_last_pc;
    inst = bus1.in_last_inst;
    if (rst) begin
      for (int i = 0; i < 64; i++) tbl_m[i] = 1;
      pc_m[0] = 32'h100; pc_m[1] = 32'h100; cnt_m = 0;
    end else if (bus1.ena) begin
      for (int m = 0; m < 2; m++) begin
        if (bus1.in_misbranch) pc_m[m] = bus1.in_forwarding_correct_address;
        else if (bus1.in_fetcher_ena) begin
          if (inst[6:0] == 7'b1101111) pc_m[m] = pc + 32'(j_offset(inst));
          else if (model_taken(m, pc, inst)) pc_m[m] = pc + 32'(b_offset(inst));
          else pc_m[m] = pc + 32'd4;
        end
      end
      if (bus1.in_update_valid) begin
        int k;
        k = idx_of(bus1.in_forwarding_branch_pc);
        if (bus1.in_forwarding_branch_taken) tbl_m[k] = (tbl_m[k] < 3) ? tbl_m[k] + 1 : 3;
        else tbl_m[k] = (tbl_m[k] > 0) ? tbl_m[k] - 1 : 0;
      end
      if (bus1.in_misbranch && cnt_m < 65535) cnt_m++;
    end
  endtask

  task automatic apply();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus1.ena = 1'b1; bus1.in_fetcher_ena = 1'b0; bus1.in_last_pc = '0; bus1.in_last_inst = INST_ALU;
    bus1.in_misbranch = 1'b0; bus1.in_update_valid = 1'b0; bus1.in_forwarding_branch_taken = 1'b0;
    bus1.in_forwarding_branch_pc = '0; bus1.in_forwarding_correct_address = '0;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input int n);
    idle();
    bus1.in_update_valid = 1'b1; bus1.in_forwarding_branch_pc = pc; bus1.in_forwarding_branch_taken = tk;
    for (int i = 0; i < n; i++) apply();
    idle();
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
    idle();
    bus1.in_fetcher_ena = 1'b1; bus1.in_last_pc = pc; bus1.in_last_inst = inst;
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus1.in_misbranch = 1'b1; bus1.in_forwarding_correct_address = 32'hDEAD0000;
    bus1.in_fetcher_ena = 1'b1; bus1.in_last_inst = INST_JAL8;
    bus1.in_update_valid = 1'b1; bus1.in_forwarding_branch_taken = 1'b1;
    rst = 1'b1;
    apply(); apply();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (npc[m] !== 32'h100) begin miscompares++; $display("FAIL reset_pc mode%0d: got %h want %h", m, npc[m], 32'h100); end
      vectors++;
      if (mcnt[m] !== 16'd0) begin miscompares++; $display("FAIL reset_cnt mode%0d: got %0d want 0", m, mcnt[m]); end
    end
    fetch(32'h0, INST_BEQ16);
    vectors++;
    if (ntk[1] !== 1'b0) begin miscompares++; $display("FAIL reset_taken: got %b want 0", ntk[1]); end
    idle();
    #1;
  endtask

  task automatic test_sequential_jal();
    fetch(32'h200, INST_ALU); apply();
    vectors++;
    if (npc[1] !== 32'h204) begin miscompares++; $display("FAIL seq_pc4: got %h want 00000204", npc[1]); end
    fetch(32'h204, INST_JAL8); apply();
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (npc[m] !== 32'h1FC) begin miscompares++; $display("FAIL jal mode%0d: got %h want 000001fc", m, npc[m]); end
    end
  endtask

  task automatic test_training();
    train(32'h40, 1'b1, 2);
    fetch(32'h40, INST_BEQ16);
    vectors++;
    if (ntk[1] !== 1'b1) begin miscompares++; $display("FAIL train_taken: got %b want 1", ntk[1]); end
    vectors++;
    if (ntk[0] !== 1'b0) begin miscompares++; $display("FAIL mode0_taken: got %b want 0", ntk[0]); end
    apply();
    vectors++;
    if (npc[1] !== 32'h50) begin miscompares++; $display("FAIL train_target: got %h want 00000050", npc[1]); end
    vectors++;
    if (npc[0] !== 32'h44) begin miscompares++; $display("FAIL mode0_target: got %h want 00000044", npc[0]); end
    train(32'h40, 1'b0, 3);
    fetch(32'h40, INST_BEQ16);
    vectors++;
    if (ntk[1] !== 1'b0) begin miscompares++; $display("FAIL untrain_taken: got %b want 0", ntk[1]); end
    apply();
    vectors++;
    if (npc[1] !== 32'h44) begin miscompares++; $display("FAIL untrain_target: got %h want 00000044", npc[1]); end
  endtask

  task automatic test_saturation_alias();
    train(32'h40, 1'b1, 5);
    train(32'h40, 1'b0, 1);
    // Saturated at 3, one decrement leaves 2: still taken, seen through alias 0x140.
    fetch(32'h140, INST_BEQ16);
    vectors++;
    if (ntk[1] !== 1'b1) begin miscompares++; $display("FAIL sat_alias_taken: got %b want 1", ntk[1]); end
    apply();
    vectors++;
    if (npc[1] !== 32'h150) begin miscompares++; $display("FAIL sat_alias_target: got %h want 00000150", npc[1]); end
    // Same-cycle lookup and update: lookup sees the old value (2 -> taken).
    fetch(32'h40, INST_BEQ16);
    bus1.in_update_valid = 1'b1; bus1.in_forwarding_branch_pc = 32'h40; bus1.in_forwarding_branch_taken = 1'b0;
    #1;
    vectors++;
    if (ntk[1] !== 1'b1) begin miscompares++; $display("FAIL same_cycle_taken: got %b want 1", ntk[1]); end
    apply();
    vectors++;
    if (npc[1] !== 32'h50) begin miscompares++; $display("FAIL same_cycle_target: got %h want 00000050", npc[1]); end
    fetch(32'h40, INST_BEQ16);
    vectors++;
    if (ntk[1] !== 1'b0) begin miscompares++; $display("FAIL after_update_taken: got %b want 0", ntk[1]); end
    idle();
  endtask

  task automatic test_priority();
    int cnt_before;
    cnt_before = int'(mcnt[1]);
    fetch(32'h40, INST_JAL8);
    bus1.in_misbranch = 1'b1; bus1.in_forwarding_correct_address = 32'h800;
    bus1.in_update_valid = 1'b1; bus1.in_forwarding_branch_pc = 32'h40; bus1.in_forwarding_branch_taken = 1'b1;
    #1;
    vectors++;
    if (rb[1] !== 1'b1 || rbpc[1] !== 32'h800) begin
      miscompares++; $display("FAIL rollback: got %b/%h want 1/00000800", rb[1], rbpc[1]);
    end
    apply();
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (npc[m] !== 32'h800) begin miscompares++; $display("FAIL prio_pc mode%0d: got %h want 00000800", m, npc[m]); end
    end
    vectors++;
    if (int'(mcnt[1]) !== cnt_before + 1) begin
      miscompares++; $display("FAIL prio_cnt: got %0d want %0d", mcnt[1], cnt_before + 1);
    end
    fetch(32'h40, INST_BEQ16);
    vectors++;
    if (ntk[1] !== 1'b1) begin miscompares++; $display("FAIL prio_trained: got %b want 1", ntk[1]); end
    idle();
  endtask

  task automatic test_enable();
    logic [31:0] held;
    int cnt_before;
    held = npc[1];
    cnt_before = int'(mcnt[1]);
    fetch(32'h300, INST_JAL8);
    bus1.ena = 1'b0; bus1.in_misbranch = 1'b1; bus1.in_forwarding_correct_address = 32'h900;
    bus1.in_update_valid = 1'b1; bus1.in_forwarding_branch_pc = 32'h40; bus1.in_forwarding_branch_taken = 1'b0;
    #1;
    vectors++;
    if (rb[1] !== 1'b1 || rbpc[1] !== 32'h900) begin
      miscompares++; $display("FAIL ena_rollback: got %b/%h want 1/00000900", rb[1], rbpc[1]);
    end
    apply(); apply();
    vectors++;
    if (npc[1] !== held) begin miscompares++; $display("FAIL ena_hold_pc: got %h want %h", npc[1], held); end
    vectors++;
    if (int'(mcnt[1]) !== cnt_before) begin miscompares++; $display("FAIL ena_hold_cnt: got %0d want %0d", mcnt[1], cnt_before); end
    fetch(32'h40, INST_BEQ16);
    vectors++;
    if (ntk[1] !== 1'b1) begin miscompares++; $display("FAIL ena_hold_table: got %b want 1", ntk[1]); end
    idle();
  endtask

  task automatic test_random();
    logic [6:0] ops [4];
    ops[0] = 7'b1100011; ops[1] = 7'b1101111; ops[2] = 7'b0010011; ops[3] = 7'b1100111;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      rst = ($urandom_range(0, 99) == 0);
      r = $urandom;
      bus1.ena = ($urandom_range(0, 9) != 0);
      bus1.in_fetcher_ena = ($urandom_range(0, 3) != 0);
      bus1.in_last_pc = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 15), 2'b00} - 32'd16
                                                       : 32'($urandom_range(0, 511)) * 4;
      bus1.in_last_inst = {r[31:7], ops[$urandom_range(0, 3)]};
      bus1.in_misbranch = ($urandom_range(0, 7) == 0);
      bus1.in_forwarding_correct_address = {$urandom, 2'b00} >> 2 << 2;
      bus1.in_update_valid = ($urandom_range(0, 1) == 1);
      bus1.in_forwarding_branch_taken = ($urandom_range(0, 2) != 0);
      bus1.in_forwarding_branch_pc = 32'($urandom_range(0, 511)) * 4;
      #1;
      if (!rst) begin
        for (int m = 0; m < 2; m++) begin
          logic exp_tk;
          exp_tk = model_taken(m, bus1.in_last_pc, bus1.in_last_inst);
          vectors++;
          if (ntk[m] !== exp_tk) begin
            miscompares++; $display("FAIL rnd_taken #%0d mode%0d: got %b want %b", n, m, ntk[m], exp_tk);
          end
        end
      end
      apply();
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (npc[m] !== pc_m[m]) begin
          miscompares++; $display("FAIL rnd_pc #%0d mode%0d: got %h want %h", n, m, npc[m], pc_m[m]);
        end
        vectors++;
        if (int'(mcnt[m]) !== cnt_m) begin
          miscompares++; $display("FAIL rnd_cnt #%0d mode%0d: got %0d want %0d", n, m, mcnt[m], cnt_m);
        end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_sequential_jal();
    test_training();
    test_saturation_alias();
    test_priority();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
